// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the CPU memory subsystem.
//   DEF_DWIDTH / DEF_ADDR_WIDTH : default memory data and address widths
//   port_id_t, PORT_CPU/PORT_DMA : requester identifiers used by the arbiter
//   arb_state_t                  : arbiter states (ARB = open, LOCK0 = CPU owns memory)
package cpu_pkg;

    localparam int DEF_DWIDTH     = 16;
    localparam int DEF_ADDR_WIDTH = 12;

    typedef logic port_id_t;
    localparam port_id_t PORT_CPU = 1'b0;
    localparam port_id_t PORT_DMA = 1'b1;

    typedef enum logic {
        ARB   = 1'b0,
        LOCK0 = 1'b1
    } arb_state_t;

endpackage

// File: rtl/mem_rd_tag_pipe.sv
// mem_rd_tag_pipe: tracks which port owns each in-flight memory read so the
// read-valid strobe can be routed back to the right requester.
//   clk, reset  : clock, asynchronous active-high reset (drops in-flight reads)
//   i_push      : a read was granted this cycle
//   i_port      : port that was granted the read
//   o_rvalid0/1 : memory read data on the shared bus belongs to port 0 / 1
// A read granted in cycle N is issued in N+1 and its data is valid in
// N+1+RD_LATENCY, so the tag needs RD_LATENCY+1 register stages.
module mem_rd_tag_pipe
    import cpu_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     i_push,
    input  port_id_t i_port,
    output logic     o_rvalid0,
    output logic     o_rvalid1
);

    localparam int DEPTH = RD_LATENCY + 1;

    logic [DEPTH-1:0] vld_p;
    logic [DEPTH-1:0] port_p;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p  <= '0;
            port_p <= '0;
        end else begin
            vld_p  <= {vld_p[DEPTH-2:0], i_push};
            port_p <= {port_p[DEPTH-2:0], i_port};
        end
    end

    assign o_rvalid0 = vld_p[DEPTH-1] && (port_p[DEPTH-1] == PORT_CPU);
    assign o_rvalid1 = vld_p[DEPTH-1] && (port_p[DEPTH-1] == PORT_DMA);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port instruction/data memory between the
// CPU (port 0) and the DMA/IO engine (port 1).
//   clk, reset                      : clock, asynchronous active-high reset
//   i_req/i_we/i_addr/i_wdata 0/1   : requests, held until the matching o_gnt
//   i_lock0                         : CPU keeps ownership after this access
//   o_gnt0/1                        : request accepted this cycle (combinational)
//   o_rvalid0/1, o_rdata            : read data return, routed to the owner
//   o_mem_ce/we/addr/data, i_mem_data : registered memory port
// Port 0 has fixed priority; port 1 overrides after MAX_WAIT denied cycles,
// except while port 0 holds the lock for an atomic read-modify-write.
module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int DWIDTH     = DEF_DWIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int RD_LATENCY = 1,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_req0,
    input  logic                  i_we0,
    input  logic [ADDR_WIDTH-1:0] i_addr0,
    input  logic [DWIDTH-1:0]     i_wdata0,
    input  logic                  i_lock0,
    output logic                  o_gnt0,
    output logic                  o_rvalid0,
    input  logic                  i_req1,
    input  logic                  i_we1,
    input  logic [ADDR_WIDTH-1:0] i_addr1,
    input  logic [DWIDTH-1:0]     i_wdata1,
    output logic                  o_gnt1,
    output logic                  o_rvalid1,
    output logic [DWIDTH-1:0]     o_rdata,
    output logic                  o_mem_ce,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DWIDTH-1:0]     o_mem_data,
    input  logic [DWIDTH-1:0]     i_mem_data
);

    localparam logic [3:0] WAIT_SAT = 4'(MAX_WAIT);

    arb_state_t state_q;
    logic [3:0] wait_q;
    logic       starve;

    logic                  grant;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DWIDTH-1:0]     sel_wdata;
    port_id_t              sel_port;

    // Grant decision: registered state plus live requests.
    always_comb begin
        o_gnt0 = 1'b0;
        o_gnt1 = 1'b0;
        starve = i_req1 && (wait_q == WAIT_SAT);
        if (!reset) begin
            if (state_q == LOCK0) begin
                o_gnt0 = i_req0;
            end else if (starve) begin
                o_gnt1 = 1'b1;
            end else if (i_req0) begin
                o_gnt0 = 1'b1;
            end else if (i_req1) begin
                o_gnt1 = 1'b1;
            end
        end
    end

    assign grant     = o_gnt0 | o_gnt1;
    assign sel_port  = o_gnt1 ? PORT_DMA : PORT_CPU;
    assign sel_we    = o_gnt1 ? i_we1    : i_we0;
    assign sel_addr  = o_gnt1 ? i_addr1  : i_addr0;
    assign sel_wdata = o_gnt1 ? i_wdata1 : i_wdata0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ARB;
            wait_q     <= '0;
            o_mem_ce   <= 1'b0;
            o_mem_we   <= 1'b0;
            o_mem_addr <= '0;
            o_mem_data <= '0;
        end else begin
            o_mem_ce <= grant;
            o_mem_we <= grant && sel_we;
            // Address and data hold between accesses to avoid needless toggling.
            if (grant) begin
                o_mem_addr <= sel_addr;
                o_mem_data <= sel_wdata;
            end

            // Counts port 1 denials, including those while port 0 holds the lock.
            if (o_gnt1 || !i_req1) begin
                wait_q <= '0;
            end else if (wait_q < WAIT_SAT) begin
                wait_q <= wait_q + 4'd1;
            end

            case (state_q)
                ARB: begin
                    if (o_gnt0 && i_lock0) begin
                        state_q <= LOCK0;
                    end
                end
                LOCK0: begin
                    // In LOCK0 o_gnt0 equals i_req0, so dropping i_lock0 covers
                    // both the unlocking access and an abandoned lock.
                    if (!i_lock0) begin
                        state_q <= ARB;
                    end
                end
                default: state_q <= ARB;
            endcase
        end
    end

    mem_rd_tag_pipe #(
        .RD_LATENCY(RD_LATENCY)
    ) u_tag_pipe (
        .clk       (clk),
        .reset     (reset),
        .i_push    (grant && !sel_we),
        .i_port    (sel_port),
        .o_rvalid0 (o_rvalid0),
        .o_rvalid1 (o_rvalid1)
    );

    assign o_rdata = i_mem_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus for mem_arbiter with a behavioural
// model checked every cycle, a small memory responder, and literal checks
// for the scenarios of interest (RD_LATENCY=1, MAX_WAIT=4).
module tb_mem_arbiter;

    localparam int DW  = 16;
    localparam int AW  = 12;
    localparam int RDL = 1;
    localparam int MW  = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          i_req0 = 1'b0, i_we0 = 1'b0, i_lock0 = 1'b0;
    logic [AW-1:0] i_addr0 = '0;
    logic [DW-1:0] i_wdata0 = '0;
    logic          i_req1 = 1'b0, i_we1 = 1'b0;
    logic [AW-1:0] i_addr1 = '0;
    logic [DW-1:0] i_wdata1 = '0;
    logic          o_gnt0, o_gnt1, o_rvalid0, o_rvalid1;
    logic [DW-1:0] o_rdata;
    logic          o_mem_ce, o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_mem_data;
    logic [DW-1:0] i_mem_data = '0;

    mem_arbiter #(
        .DWIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(RDL), .MAX_WAIT(MW)
    ) dut (
        .clk(clk), .reset(reset),
        .i_req0(i_req0), .i_we0(i_we0), .i_addr0(i_addr0), .i_wdata0(i_wdata0),
        .i_lock0(i_lock0), .o_gnt0(o_gnt0), .o_rvalid0(o_rvalid0),
        .i_req1(i_req1), .i_we1(i_we1), .i_addr1(i_addr1), .i_wdata1(i_wdata1),
        .o_gnt1(o_gnt1), .o_rvalid1(o_rvalid1), .o_rdata(o_rdata),
        .o_mem_ce(o_mem_ce), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_data(o_mem_data), .i_mem_data(i_mem_data)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory responder: samples the memory port mid-cycle, returns read data
    // one cycle after the access cycle.
    logic [DW-1:0] mem [0:4095];
    logic [DW-1:0] rd_next = '0;

    always @(negedge clk) begin
        if (o_mem_ce === 1'b1) begin
            if (o_mem_we) mem[o_mem_addr] = o_mem_data;
            else          rd_next = mem[o_mem_addr];
        end
    end

    always @(posedge clk) begin
        #1;
        i_mem_data = rd_next;
    end

    // Behavioural model: per-cycle grant decision from the arbitration rules,
    // expected memory-port contents from the previous grant, and a list of
    // pending read returns keyed by the cycle they are due.
    typedef struct {
        int          due;
        bit          port;
        logic [DW-1:0] data;
    } rd_t;

    rd_t           pend[$];
    logic [DW-1:0] mmem [0:4095];
    int            cyc = 0;
    int            m_wait = 0;
    bit            m_locked = 1'b0;
    bit            m_ce = 1'b0, m_we = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;
    bit            e0, e1, w0, w1;
    logic [DW-1:0] erd;

    always @(negedge clk) begin
        if (reset) begin
            chk("rst_gnt0", o_gnt0, 0);
            chk("rst_gnt1", o_gnt1, 0);
            chk("rst_ce", o_mem_ce, 0);
            chk("rst_we", o_mem_we, 0);
            chk("rst_addr", o_mem_addr, 0);
            chk("rst_data", o_mem_data, 0);
            chk("rst_rvalid0", o_rvalid0, 0);
            chk("rst_rvalid1", o_rvalid1, 0);
            pend.delete();
            m_wait = 0; m_locked = 1'b0;
            m_ce = 1'b0; m_we = 1'b0; m_addr = '0; m_data = '0;
        end else begin
            e0 = 1'b0; e1 = 1'b0; erd = '0;
            foreach (pend[i]) begin
                if (pend[i].due == cyc) begin
                    if (pend[i].port) e1 = 1'b1; else e0 = 1'b1;
                    erd = pend[i].data;
                end
            end
            chk("m_ce", o_mem_ce, m_ce);
            chk("m_we", o_mem_we, m_we);
            chk("m_addr", o_mem_addr, m_addr);
            chk("m_data", o_mem_data, m_data);
            chk("m_rvalid0", o_rvalid0, e0);
            chk("m_rvalid1", o_rvalid1, e1);
            if (e0 || e1) chk("m_rdata", o_rdata, erd);

            w0 = 1'b0; w1 = 1'b0;
            if (m_locked)                      w0 = i_req0;
            else if (i_req1 && m_wait >= MW)   w1 = 1'b1;
            else if (i_req0)                   w0 = 1'b1;
            else if (i_req1)                   w1 = 1'b1;
            chk("m_gnt0", o_gnt0, w0);
            chk("m_gnt1", o_gnt1, w1);

            while (pend.size() > 0 && pend[0].due <= cyc) void'(pend.pop_front());

            if (w1 || !i_req1)  m_wait = 0;
            else if (m_wait < MW) m_wait = m_wait + 1;

            if (!m_locked && w0 && i_lock0) m_locked = 1'b1;
            else if (m_locked && !i_lock0)  m_locked = 1'b0;

            m_ce = w0 || w1;
            m_we = (w0 && i_we0) || (w1 && i_we1);
            if (w0 || w1) begin
                m_addr = w1 ? i_addr1 : i_addr0;
                m_data = w1 ? i_wdata1 : i_wdata0;
                if (m_we) mmem[m_addr] = m_data;
                else pend.push_back('{cyc + 1 + RDL, w1, mmem[m_addr]});
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_req0 = 1'b0; i_we0 = 1'b0; i_lock0 = 1'b0;
        i_req1 = 1'b0; i_we1 = 1'b0;
    endtask

    logic [DW-1:0] v6 [3];

    initial begin
        for (int a = 0; a < 4096; a++) begin
            mem[a] = '0;
            mmem[a] = '0;
        end
        mem[12'h010] = 16'hBEEF;
        mmem[12'h010] = 16'hBEEF;
        v6[0] = 16'h1111; v6[1] = 16'h2222; v6[2] = 16'h3333;

        // 1: reset held with random inputs
        #1 reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            i_req0 = 1'($urandom); i_we0 = 1'($urandom); i_lock0 = 1'($urandom);
            i_addr0 = AW'($urandom); i_wdata0 = DW'($urandom);
            i_req1 = 1'($urandom); i_we1 = 1'($urandom);
            i_addr1 = AW'($urandom); i_wdata1 = DW'($urandom);
            @(negedge clk);
            chk("t1_gnt0", o_gnt0, 0);
            chk("t1_gnt1", o_gnt1, 0);
        end
        tick();
        reset = 1'b0;
        idle();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t1_no_ce", o_mem_ce, 0);
            tick();
        end

        // 2: single port 0 read of 0x010
        i_req0 = 1'b1; i_we0 = 1'b0; i_addr0 = 12'h010;
        @(negedge clk);
        chk("t2_gnt0", o_gnt0, 1);
        tick();
        idle();
        @(negedge clk);
        chk("t2_ce", o_mem_ce, 1);
        chk("t2_we", o_mem_we, 0);
        chk("t2_addr", o_mem_addr, 12'h010);
        tick();
        @(negedge clk);
        chk("t2_rvalid0", o_rvalid0, 1);
        chk("t2_rdata", o_rdata, 16'hBEEF);
        chk("t2_rvalid1", o_rvalid1, 0);
        repeat (2) tick();

        // 3: both ports requesting continuously
        i_req0 = 1'b1; i_we0 = 1'b0; i_addr0 = 12'h011;
        i_req1 = 1'b1; i_we1 = 1'b0; i_addr1 = 12'h200;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("t3_gnt1", o_gnt1, (k % 5 == 4) ? 1 : 0);
            chk("t3_gnt0", o_gnt0, (k % 5 == 4) ? 0 : 1);
            tick();
        end
        idle();
        repeat (3) tick();

        // 4: locked read-modify-write with port 1 waiting throughout
        i_req0 = 1'b1; i_we0 = 1'b0; i_addr0 = 12'h020; i_lock0 = 1'b1;
        i_req1 = 1'b1; i_we1 = 1'b0; i_addr1 = 12'h210;
        @(negedge clk);
        chk("t4_lock_gnt0", o_gnt0, 1);
        chk("t4_lock_gnt1", o_gnt1, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            i_req0 = 1'b0;
            @(negedge clk);
            chk("t4_held_gnt1", o_gnt1, 0);
        end
        tick();
        i_req0 = 1'b1; i_we0 = 1'b1; i_wdata0 = 16'h0005; i_lock0 = 1'b0;
        @(negedge clk);
        chk("t4_wr_gnt0", o_gnt0, 1);
        chk("t4_wr_gnt1", o_gnt1, 0);
        tick();
        i_we0 = 1'b0; i_addr0 = 12'h021;
        @(negedge clk);
        chk("t4_starve_gnt1", o_gnt1, 1);
        chk("t4_starve_gnt0", o_gnt0, 0);
        tick();
        i_req1 = 1'b0;
        @(negedge clk);
        chk("t4_after_gnt0", o_gnt0, 1);
        tick();
        idle();
        repeat (3) tick();

        // 5: locked read, reset on the following cycle
        i_req0 = 1'b1; i_we0 = 1'b0; i_addr0 = 12'h030; i_lock0 = 1'b1;
        @(negedge clk);
        chk("t5_gnt0", o_gnt0, 1);
        tick();
        reset = 1'b1;
        idle();
        @(negedge clk);
        chk("t5_rst_ce", o_mem_ce, 0);
        tick();
        reset = 1'b0;
        i_req1 = 1'b1; i_we1 = 1'b0; i_addr1 = 12'h300;
        @(negedge clk);
        chk("t5_dropped_rvalid0", o_rvalid0, 0);
        chk("t5_unlocked_gnt1", o_gnt1, 1);
        tick();
        idle();
        repeat (3) tick();

        // 6: three back-to-back port 1 writes
        for (int k = 0; k < 3; k++) begin
            i_req1 = 1'b1; i_we1 = 1'b1;
            i_addr1 = 12'h100 + 12'(k); i_wdata1 = v6[k];
            @(negedge clk);
            chk("t6_gnt1", o_gnt1, 1);
            if (k > 0) begin
                chk("t6_ce", o_mem_ce, 1);
                chk("t6_we", o_mem_we, 1);
                chk("t6_addr", o_mem_addr, 12'h100 + 12'(k - 1));
                chk("t6_data", o_mem_data, v6[k-1]);
            end
            tick();
        end
        idle();
        @(negedge clk);
        chk("t6_ce_last", o_mem_ce, 1);
        chk("t6_addr_last", o_mem_addr, 12'h102);
        chk("t6_data_last", o_mem_data, 16'h3333);
        tick();
        @(negedge clk);
        chk("t6_ce_off", o_mem_ce, 0);
        tick();
        repeat (2) tick();
        chk("mem_100", mem[12'h100], 16'h1111);
        chk("mem_101", mem[12'h101], 16'h2222);
        chk("mem_102", mem[12'h102], 16'h3333);
        chk("mem_020", mem[12'h020], 16'h0005);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
